// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared constants for the adder_share_ctrl scheduler.
// State encoding is kept as plain 2-bit constants so legacy tools and
// waveform viewers see the same numeric values (IDLE=0 .. ACK=3).
package adder_share_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    // Largest supported requester count.
    localparam int N_REQ_MAX = 4;

    // Default watchdog limit, in WAIT cycles.
    localparam int TIMEOUT_DEFAULT = 64;

    // Width of a requester index; never zero, even for degenerate counts.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Search starts at ptr and wraps
// upward; the first asserted req wins. Outputs a one-hot grant and the
// binary index of the winner (both zero when nothing is requesting).
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);

    logic [IW:0] cand;
    logic        found;

    // Walk the requesters in priority order ptr, ptr+1, ... modulo N_REQ.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ))
                cand = cand - (IW+1)'(N_REQ);
            if (!found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                grant[cand[IW-1:0]]  = 1'b1;
                idx                  = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: shares one adder control unit + datapath among N_REQ
// requesters. IDLE picks a winner round-robin and latches its operands,
// GRANT pulses S, WAIT holds until done, ACK returns the result.
// Optional watchdog: define ADDSHARE_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles (result forced to 0, err pulsed with ack).
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] opA,
    input  logic [N_REQ*WIDTH-1:0] opB,
    output logic                   S,
    output logic [WIDTH-1:0]       A_bus,
    output logic [WIDTH-1:0]       B_bus,
    input  logic                   done,
    input  logic [WIDTH-1:0]       res_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       result,
    output logic                   busy,
    output logic                   err
);

    localparam int IW = idx_w(N_REQ);

    // Reject unsupported configurations at elaboration.
    if (N_REQ < 2 || N_REQ > N_REQ_MAX || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("adder_share_ctrl: unsupported N_REQ/TIMEOUT_CYCLES");
    end

    logic [1:0]                  state;
    logic [IW-1:0]               ptr;
    logic [IW-1:0]               win;
    logic [N_REQ-1:0]            arb_gnt;
    logic [IW-1:0]               arb_idx;
    logic [N_REQ-1:0][WIDTH-1:0] a_arr;
    logic [N_REQ-1:0][WIDTH-1:0] b_arr;

    assign a_arr = opA;
    assign b_arr = opB;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_gnt),
        .idx   (arb_idx)
    );

    // Outputs that are pure state decodes; gnt is still valid in ACK.
    assign S    = (state == GRANT);
    assign busy = (state != IDLE);
    assign ack  = (state == ACK) ? gnt : '0;

`ifdef ADDSHARE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Main sequencer: arbitration, operand latch, done capture, pointer advance.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state  <= IDLE;
            ptr    <= '0;
            win    <= '0;
            gnt    <= '0;
            A_bus  <= '0;
            B_bus  <= '0;
            result <= '0;
`ifdef ADDSHARE_TIMEOUT_EN
            cnt    <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        A_bus <= a_arr[arb_idx];
                        B_bus <= b_arr[arb_idx];
                        gnt   <= arb_gnt;
                        win   <= arb_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
`ifdef ADDSHARE_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        result <= res_in;
                        state  <= ACK;
                    end
`ifdef ADDSHARE_TIMEOUT_EN
                    // WAIT lasts at most TIMEOUT_CYCLES cycles; a late done loses.
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        result <= '0;
                        err_q  <= 1'b1;
                        state  <= ACK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                ACK: begin
                    gnt   <= '0;
                    ptr   <= (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
`ifdef ADDSHARE_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: directed scoreboard bench. Stimulus pushes expected
// operations into op_q; an adder model consumes them on S, checks the
// operand bus and answers with done; the monitor checks every ack pulse.
module tb_adder_share_ctrl;

    localparam int N = 2;
    localparam int W = 8;
    localparam int T = 8;

    logic           clk = 1'b0;
    logic           RESET;
    logic [N-1:0]   req;
    logic [N*W-1:0] opA, opB;
    logic           S;
    logic [W-1:0]   A_bus, B_bus;
    logic           done;
    logic [W-1:0]   res_in;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   result;
    logic           busy, err;

    logic mdone     = 1'b0;
    logic spur_done = 1'b0;
    assign done = mdone | spur_done;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct { int id; logic [7:0] a; logic [7:0] b; logic [7:0] res; int lat; } op_t;
    typedef struct { int id; logic [7:0] res; logic err; int cyc; } ak_t;

    op_t op_q[$];
    ak_t ack_q[$];

    adder_share_ctrl #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .RESET(RESET), .req(req), .opA(opA), .opB(opB),
        .S(S), .A_bus(A_bus), .B_bus(B_bus), .done(done), .res_in(res_in),
        .gnt(gnt), .ack(ack), .result(result), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Adder control unit model: on S, check operands, then raise done after lat cycles.
    initial begin : adder_model
        op_t o;
        int  g;
        bit  aborted;
        res_in = '0;
        forever begin
            @(negedge clk);
            if (S) begin
                g = cyc;
                checks++;
                if (op_q.size() == 0) begin
                    failures++;
                    $display("FAIL start_without_request: S=1 with no queued op (cycle %0d)", cyc);
                end else begin
                    o = op_q.pop_front();
                    chk("start_gnt", 32'(gnt), 32'(1) << o.id);
                    chk("A_bus", 32'(A_bus), 32'(o.a));
                    chk("B_bus", 32'(B_bus), 32'(o.b));
                    chk("busy_grant", 32'(busy), 32'd1);
                    if (o.lat == 0) begin
                        ack_q.push_back('{o.id, 8'h00, 1'b1, g + 1 + T});
                    end else begin
                        aborted = 1'b0;
                        for (int i = 0; i < o.lat; i++) begin
                            @(negedge clk);
                            #1;
                            if (RESET) begin
                                aborted = 1'b1;
                                break;
                            end
                        end
                        if (!aborted) begin
                            mdone  = 1'b1;
                            res_in = o.res;
                            ack_q.push_back('{o.id, o.res, 1'b0, g + o.lat + 1});
                            @(negedge clk);
                            mdone = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: every ack pulse must match the oldest outstanding completion.
    initial begin : monitor
        ak_t k;
        forever begin
            @(negedge clk);
            if (ack != '0) begin
                checks++;
                if (ack_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_ack: ack=%b with nothing outstanding (cycle %0d)", ack, cyc);
                end else begin
                    k = ack_q.pop_front();
                    chk("ack_owner", 32'(ack), 32'(1) << k.id);
                    chk("ack_gnt", 32'(gnt), 32'(1) << k.id);
                    chk("result", 32'(result), 32'(k.res));
                    chk("err", 32'(err), 32'(k.err));
                    chk("ack_cycle", 32'(cyc), 32'(k.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
        opA[id*W +: W] = a;
        opB[id*W +: W] = b;
    endtask

    task automatic wait_s(input string name);
        int n = 0;
        while (!S && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!S) begin
            checks++;
            failures++;
            $display("FAIL %s: S never seen within 20 cycles", name);
        end
    endtask

    task automatic wait_ack(input int id, input int bound);
        int n = 0;
        while (!ack[id] && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!ack[id]) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: requester %0d no ack within %0d cycles", id, bound);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || op_q.size() != 0 || ack_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin : stimulus
        int  r;
        int  cnt[N];
        int  total;
        int  n;
        int  kk;
        logic [7:0] a_t[6], b_t[6], r_t[6];
        int  lat_t[6];

        RESET = 1'b1;
        req   = '0;
        opA   = '0;
        opB   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_S", 32'(S), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_A_bus", 32'(A_bus), 0);
        chk("rst_B_bus", 32'(B_bus), 0);
        chk("rst_result", 32'(result), 0);
        RESET = 1'b0;
        @(negedge clk);

        // Spurious done while IDLE must be ignored
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("idle_done_busy", 32'(busy), 0);
        chk("idle_done_S", 32'(S), 0);
        @(negedge clk);
        chk("idle_done_busy2", 32'(busy), 0);

        // Single request, 4-cycle adder, spurious done during GRANT
        op_q.push_back('{0, 8'h05, 8'hFD, 8'h02, 4});
        set_op(0, 8'h05, 8'hFD);
        req = 2'b01;
        r   = cyc;
        wait_s("single_S");
        chk("single_S_cycle", 32'(cyc), 32'(r + 1));
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("single_wait_gnt", 32'(gnt), 32'b01);
        chk("single_wait_busy", 32'(busy), 1);
        wait_ack(0, 20);
        chk("single_ack_cycle", 32'(cyc), 32'(r + 6));
        req = '0;
        wait_idle();

        // Boundary operands from requester 1
        op_q.push_back('{1, 8'h7F, 8'h80, 8'hFF, 2});
        set_op(1, 8'h7F, 8'h80);
        req = 2'b10;
        wait_ack(1, 20);
        req = '0;
        wait_idle();

        // Reset while in WAIT aborts the operation with no ack
        op_q.push_back('{0, 8'h11, 8'h22, 8'h33, 10});
        set_op(0, 8'h11, 8'h22);
        req = 2'b01;
        wait_s("rst_mid_S");
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_busy_before", 32'(busy), 1);
        RESET = 1'b1;
        req   = '0;
        @(negedge clk);
        RESET = 1'b0;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_gnt", 32'(gnt), 0);
        chk("rst_mid_A_bus", 32'(A_bus), 0);
        op_q.push_back('{1, 8'h40, 8'h3F, 8'h7F, 1});
        set_op(1, 8'h40, 8'h3F);
        req = 2'b10;
        wait_ack(1, 20);
        req = '0;
        wait_idle();

        // Contention: both requesters held high from reset, 3 ops each
        a_t   = '{8'h01, 8'h7F, 8'h10, 8'hFF, 8'h80, 8'h33};
        b_t   = '{8'h02, 8'h01, 8'hF0, 8'hFF, 8'h80, 8'h44};
        r_t   = '{8'h03, 8'h80, 8'h00, 8'hFE, 8'h00, 8'h77};
        lat_t = '{1, 2, 3, 1, 2, 3};
        for (int k = 0; k < 6; k++)
            op_q.push_back('{k % 2, a_t[k], b_t[k], r_t[k], lat_t[k]});
        set_op(0, a_t[0], b_t[0]);
        set_op(1, a_t[1], b_t[1]);
        req   = 2'b11;
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        cnt   = '{0, 0};
        total = 0;
        n     = 0;
        while (total < 6 && n < 300) begin
            @(negedge clk);
            n++;
            for (int j = 0; j < N; j++) begin
                if (ack[j]) begin
                    cnt[j]++;
                    total++;
                    if (cnt[j] == 3) begin
                        req[j] = 1'b0;
                    end else begin
                        kk = 2 * cnt[j] + j;
                        set_op(j, a_t[kk], b_t[kk]);
                    end
                end
            end
        end
        chk("contend_cnt0", 32'(cnt[0]), 3);
        chk("contend_cnt1", 32'(cnt[1]), 3);
        req = '0;
        wait_idle();

`ifdef ADDSHARE_TIMEOUT_EN
        // Watchdog: done never comes
        op_q.push_back('{0, 8'h12, 8'h34, 8'h00, 0});
        set_op(0, 8'h12, 8'h34);
        req = 2'b01;
        wait_ack(0, T + 20);
        req = '0;
        wait_idle();
`endif

        chk("op_q_empty", 32'(op_q.size()), 0);
        chk("ack_q_empty", 32'(ack_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
